// File: rtl/sw_hw_handshake_ctrl.sv
// rtl/sw_hw_handshake_ctrl.sv - PIO command sequencer with 4-phase req/ack handshake to a job engine.
// Optional WAIT_DONE watchdog enabled by defining HS_TIMEOUT_EN.
module sw_hw_handshake_ctrl #(
    parameter int ARG_W          = 32,
    parameter int RES_W          = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       to_hw_sig,
    input  logic [ARG_W-1:0] to_hw_port,
    output logic [1:0]       to_sw_sig,
    output logic [RES_W-1:0] to_sw_port,
    output logic             job_start,
    output logic [ARG_W-1:0] job_arg,
    output logic             job_abort,
    input  logic             job_done,
    input  logic             job_err,
    input  logic [RES_W-1:0] job_result,
    output logic             busy,
    output logic [CNT_W-1:0] job_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_REPORT,
        S_WAIT_ACK
    } state_t;

    localparam logic [1:0] CMD_ACK   = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_ABORT = 2'b10;

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("sw_hw_handshake_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    state_t           state, state_d;
    logic [1:0]       cmd_q;
    logic             armed, armed_d;
    logic             err_q, err_d;
    logic [1:0]       to_sw_sig_d;
    logic [RES_W-1:0] to_sw_port_d;
    logic             job_start_d;
    logic [ARG_W-1:0] job_arg_d;
    logic             job_abort_d;
    logic             busy_d;
    logic [CNT_W-1:0] job_cnt_d;
    logic             timeout_hit;

`ifdef HS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;

    // START always precedes WAIT_DONE, so clearing there gives a fresh count on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == S_START) begin
            to_cnt <= '0;
        end else if (state == S_WAIT_DONE) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state;
        armed_d      = armed;
        err_d        = err_q;
        to_sw_sig_d  = to_sw_sig;
        to_sw_port_d = to_sw_port;
        job_start_d  = 1'b0;
        job_arg_d    = job_arg;
        job_abort_d  = 1'b0;
        job_cnt_d    = job_cnt;

        case (state)
            S_IDLE: begin
                if (cmd_q == CMD_ACK) begin
                    armed_d = 1'b1;
                end else if (cmd_q == CMD_START && armed) begin
                    job_arg_d   = to_hw_port;
                    armed_d     = 1'b0;
                    job_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A completion in the same cycle as an abort request is reported as a normal finish.
                if (job_done) begin
                    to_sw_port_d = job_result;
                    err_d        = job_err;
                    state_d      = S_REPORT;
                end else if (cmd_q == CMD_ABORT || timeout_hit) begin
                    job_abort_d  = 1'b1;
                    to_sw_port_d = '0;
                    err_d        = 1'b1;
                    state_d      = S_REPORT;
                end
            end
            S_REPORT: begin
                to_sw_sig_d = {err_q, 1'b1};
                job_cnt_d   = job_cnt + CNT_W'(1);
                state_d     = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (cmd_q == CMD_ACK) begin
                    to_sw_sig_d = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_START) || (state_d == S_WAIT_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_q      <= 2'b00;
            armed      <= 1'b1;
            err_q      <= 1'b0;
            to_sw_sig  <= 2'b00;
            to_sw_port <= '0;
            job_start  <= 1'b0;
            job_arg    <= '0;
            job_abort  <= 1'b0;
            busy       <= 1'b0;
            job_cnt    <= '0;
        end else begin
            state      <= state_d;
            cmd_q      <= to_hw_sig;
            armed      <= armed_d;
            err_q      <= err_d;
            to_sw_sig  <= to_sw_sig_d;
            to_sw_port <= to_sw_port_d;
            job_start  <= job_start_d;
            job_arg    <= job_arg_d;
            job_abort  <= job_abort_d;
            busy       <= busy_d;
            job_cnt    <= job_cnt_d;
        end
    end

endmodule

// File: tb/tb_sw_hw_handshake_ctrl.sv
// tb/tb_sw_hw_handshake_ctrl.sv - directed self-checking bench for sw_hw_handshake_ctrl.
module tb_sw_hw_handshake_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  to_hw_sig;
    logic [31:0] to_hw_port;
    logic [1:0]  to_sw_sig;
    logic [31:0] to_sw_port;
    logic        job_start;
    logic [31:0] job_arg;
    logic        job_abort;
    logic        job_done;
    logic        job_err;
    logic [31:0] job_result;
    logic        busy;
    logic [3:0]  job_cnt;

    int tests  = 0;
    int fails  = 0;
    int starts = 0;
    int aborts = 0;

    sw_hw_handshake_ctrl #(
        .ARG_W(32),
        .RES_W(32),
        .CNT_W(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .to_hw_sig(to_hw_sig),
        .to_hw_port(to_hw_port),
        .to_sw_sig(to_sw_sig),
        .to_sw_port(to_sw_port),
        .job_start(job_start),
        .job_arg(job_arg),
        .job_abort(job_abort),
        .job_done(job_done),
        .job_err(job_err),
        .job_result(job_result),
        .busy(busy),
        .job_cnt(job_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (job_start) starts++;
        if (job_abort) aborts++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one job from IDLE (armed) and leaves the block in WAIT_ACK with start still requested.
    task automatic do_job(input logic [31:0] arg, input logic [31:0] res, input logic err);
        to_hw_sig = 2'b00;
        tick(2);
        to_hw_port = arg;
        to_hw_sig  = 2'b01;
        tick(3);
        job_done   = 1'b1;
        job_result = res;
        job_err    = err;
        tick(1);
        job_done = 1'b0;
        job_err  = 1'b0;
        tick(1);
    endtask

    initial begin
        reset      = 1'b1;
        to_hw_sig  = 2'b00;
        to_hw_port = '0;
        job_done   = 1'b0;
        job_err    = 1'b0;
        job_result = '0;
        tick(2);
        check("reset_to_sw_sig", 64'(to_sw_sig), 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_job_cnt", 64'(job_cnt), 64'h0);
        reset = 1'b0;
        tick(1);

        // basic job
        to_hw_port = 32'h1234;
        to_hw_sig  = 2'b01;
        tick(1);
        check("t1_no_start_yet", 64'(job_start), 64'h0);
        tick(1);
        check("t1_job_start", 64'(job_start), 64'h1);
        check("t1_job_arg", 64'(job_arg), 64'h1234);
        check("t1_busy", 64'(busy), 64'h1);
        tick(1);
        check("t1_start_one_cycle", 64'(job_start), 64'h0);
        tick(4);
        job_done   = 1'b1;
        job_result = 32'hCAFE;
        tick(1);
        job_done = 1'b0;
        check("t1_to_sw_port", 64'(to_sw_port), 64'hCAFE);
        check("t1_busy_report", 64'(busy), 64'h0);
        tick(1);
        check("t1_to_sw_sig", 64'(to_sw_sig), 64'h1);
        check("t1_job_cnt", 64'(job_cnt), 64'h1);
        to_hw_sig = 2'b00;
        tick(2);
        check("t1_ack_clear", 64'(to_sw_sig), 64'h0);
        check("t1_starts", 64'(starts), 64'h1);

        // start held through ack
        to_hw_port = 32'h55;
        to_hw_sig  = 2'b01;
        tick(3);
        job_done   = 1'b1;
        job_result = 32'h1;
        tick(1);
        job_done = 1'b0;
        tick(6);
        check("t2_single_start", 64'(starts), 64'h2);
        check("t2_hold_sig", 64'(to_sw_sig), 64'h1);
        to_hw_sig = 2'b00;
        tick(3);
        check("t2_ack", 64'(to_sw_sig), 64'h0);
        to_hw_port = 32'h77;
        to_hw_sig  = 2'b01;
        tick(2);
        check("t2_restart", 64'(job_start), 64'h1);
        check("t2_restart_arg", 64'(job_arg), 64'h77);
        tick(1);

        // software abort
        to_hw_sig = 2'b10;
        tick(2);
        check("t3_abort_pulse", 64'(job_abort), 64'h1);
        check("t3_abort_port", 64'(to_sw_port), 64'h0);
        tick(1);
        check("t3_abort_one_cycle", 64'(job_abort), 64'h0);
        check("t3_abort_sig", 64'(to_sw_sig), 64'h3);
        check("t3_abort_cnt", 64'(job_cnt), 64'h3);
        to_hw_sig = 2'b00;
        tick(3);

        // done and abort in the same cycle
        to_hw_port = 32'h99;
        to_hw_sig  = 2'b01;
        tick(3);
        to_hw_sig = 2'b10;
        tick(1);
        job_done   = 1'b1;
        job_result = 32'hBEEF;
        tick(1);
        job_done = 1'b0;
        check("t3_race_no_abort", 64'(job_abort), 64'h0);
        check("t3_race_port", 64'(to_sw_port), 64'hBEEF);
        tick(1);
        check("t3_race_sig", 64'(to_sw_sig), 64'h1);
        check("t3_race_aborts", 64'(aborts), 64'h1);
        to_hw_sig = 2'b00;
        tick(3);

        // stray job_done and reserved command
        job_done   = 1'b1;
        job_err    = 1'b1;
        job_result = 32'hDEAD;
        tick(1);
        job_done = 1'b0;
        job_err  = 1'b0;
        tick(1);
        check("t4_idle_port", 64'(to_sw_port), 64'hBEEF);
        check("t4_idle_sig", 64'(to_sw_sig), 64'h0);
        check("t4_idle_cnt", 64'(job_cnt), 64'h4);
        to_hw_sig = 2'b11;
        tick(3);
        check("t4_rsvd_busy", 64'(busy), 64'h0);
        check("t4_rsvd_starts", 64'(starts), 64'h4);
        do_job(32'h10, 32'h1111, 1'b0);
        check("t4_job_cnt", 64'(job_cnt), 64'h5);
        job_done   = 1'b1;
        job_err    = 1'b1;
        job_result = 32'h2222;
        tick(1);
        job_done = 1'b0;
        job_err  = 1'b0;
        tick(1);
        check("t4_ack_port", 64'(to_sw_port), 64'h1111);
        check("t4_ack_sig", 64'(to_sw_sig), 64'h1);
        check("t4_ack_cnt", 64'(job_cnt), 64'h5);
        to_hw_sig = 2'b00;
        tick(3);

        // watchdog
        to_hw_sig = 2'b01;
        tick(3);
`ifdef HS_TIMEOUT_EN
        tick(15);
        check("t5_before_limit", 64'(job_abort), 64'h0);
        check("t5_busy_before_limit", 64'(busy), 64'h1);
        tick(1);
        check("t5_timeout_abort", 64'(job_abort), 64'h1);
        tick(1);
        check("t5_timeout_sig", 64'(to_sw_sig), 64'h3);
        to_hw_sig = 2'b00;
        tick(3);
        to_hw_sig = 2'b01;
        tick(3);
`else
        tick(1000);
        check("t5_still_busy", 64'(busy), 64'h1);
        check("t5_no_abort", 64'(aborts), 64'h1);
`endif

        // reset while waiting for the engine
        reset     = 1'b1;
        to_hw_sig = 2'b00;
        tick(1);
        check("t6_rst_busy", 64'(busy), 64'h0);
        check("t6_rst_cnt", 64'(job_cnt), 64'h0);
        check("t6_rst_arg", 64'(job_arg), 64'h0);
        check("t6_rst_port", 64'(to_sw_port), 64'h0);
        check("t6_rst_sig", 64'(to_sw_sig), 64'h0);
        check("t6_rst_abort", 64'(job_abort), 64'h0);
        reset = 1'b0;
        tick(1);

        // counter wrap
        for (int j = 0; j < 15; j++) begin
            do_job(32'(j), 32'(j + 100), 1'b0);
        end
        check("t6_cnt_full", 64'(job_cnt), 64'hF);
        do_job(32'hAA, 32'hBB, 1'b1);
        check("t6_cnt_wrap", 64'(job_cnt), 64'h0);
        check("t6_wrap_sig", 64'(to_sw_sig), 64'h3);
        check("t6_wrap_port", 64'(to_sw_port), 64'hBB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
